match_event_monitor: RTL
========================

Name: match_event_monitor

Overview:
Downstream consumer of the serial pattern detector's single-bit match output. Edge-qualifies each match and keeps a saturating running total. Also counts matches per fixed-length time window and raises a sticky alarm when a window's count reaches a programmable threshold. Sits between the detector and the status/interrupt logic.

Parameters:
CNT_W, 8, width of all event counters and of thresh.
WIN_LEN, 256, window length in clk cycles; legal range 2..65535.
TMR_W, 16, width of the window timer; must hold WIN_LEN-1.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, synchronous, active-high.
en  in  1  monitor enable; timer and event counting run only while 1.
match_in  in  1  detector output, level, one cycle or longer per match.
clr_total  in  1  synchronous clear of total_count.
alarm_ack  in  1  clears alarm.
thresh  in  CNT_W  alarm threshold; 0 disables the alarm.
total_count  out  CNT_W  saturating count of all matches since reset/clear.
win_count  out  CNT_W  match count of the last completed window.
win_valid  out  1  one-cycle pulse: win_count just updated.
alarm  out  1  sticky threshold alarm.

Behaviour:
- Reset: all outputs 0. Internal registers reset as follows: match_q=0, timer=0, window accumulator acc=0, alarm FSM=IDLE.
- Edge qualify:
  - match_q <= match_in every cycle, regardless of en.
  - event = en & match_in & ~match_q.
  - A match_in held high N cycles counts once.
- Latency: match_in rises before edge k -> total_count updated and visible after edge k.
- total_count:
  - Increments on event; saturates at 2^CNT_W-1 with no wrap.
  - clr_total forces 0. clr_total and event in the same cycle -> 0; the event is dropped.
- Window timer:
  - en=1: counts 0..WIN_LEN-1, then wraps to 0.
  - en=0: timer, acc and win_valid hold or stay inactive; no window closes.
- acc:
  - Increments on event, saturating.
  - On the close cycle (en=1, timer==WIN_LEN-1): win_count <= sat(acc+event), acc <= 0, win_valid=1 in the following cycle only.
  - An event in the close cycle belongs to the closing window.
- Alarm FSM, states IDLE (alarm=0) and ALARM (alarm=1):
  - IDLE->ALARM when a window closes with thresh!=0 and closing count >= thresh; alarm visible the same cycle as win_valid.
  - ALARM->IDLE on alarm_ack.
  - Set condition and alarm_ack in the same cycle -> stays or enters ALARM (set wins).
  - alarm_ack in IDLE has no effect.
  - thresh is sampled only at the close cycle.
- rst asserted mid-window: everything returns to reset values next edge; the partial window is discarded and no win_valid is produced.
- en deasserted mid-window: the window is paused, not discarded; it resumes on en=1.
- win_count holds its value between closes; it is not cleared by clr_total.

Test Plan:
- Reset/idle (WIN_LEN=8): rst 2 cycles, en=1, match_in=0 for 20 cycles -> total_count=0; win_valid pulses at cycles 8 and 16 after reset release with win_count=0; alarm=0.
- Edge qualify: match_in high 5 consecutive cycles, then 3 separate 1-cycle pulses -> total_count=4; one window containing all of them gives win_count=4.
- Saturation/clear (CNT_W=4): 20 single-cycle matches -> total_count=15. clr_total coincident with a match -> 0. A next match -> 1.
- Close-cycle event and alarm (WIN_LEN=8, thresh=3): 2 matches mid-window plus 1 at timer==7 -> win_count=3, win_valid=1 and alarm=1 on the same cycle. Next window with 0 matches -> alarm stays 1. alarm_ack -> 0.
- Ack vs set collision: alarm=1, alarm_ack asserted on a close cycle whose count >= thresh -> alarm stays 1. thresh=0 with 8 matches -> alarm never sets.
- Pause and reset mid-op: en=0 for 10 cycles at timer=3 -> no win_valid, counts frozen, and match_in pulses are ignored. Re-enable -> close 5 cycles later. rst at timer=5 -> no win_valid, and the next close occurs 8 cycles after release.

Source files
------------

// File: rtl/match_event_monitor_if.sv
// Bus between the match event monitor and its driver: detector match level,
// control strobes, threshold, and the monitor's status outputs.
interface match_event_monitor_if #(
  parameter int unsigned CNT_W = 8
);
  logic             en;
  logic             match_in;
  logic             clr_total;
  logic             alarm_ack;
  logic [CNT_W-1:0] thresh;
  logic [CNT_W-1:0] total_count;
  logic [CNT_W-1:0] win_count;
  logic             win_valid;
  logic             alarm;

  modport master (
    output en,
    output match_in,
    output clr_total,
    output alarm_ack,
    output thresh,
    input  total_count,
    input  win_count,
    input  win_valid,
    input  alarm
  );

  modport slave (
    input  en,
    input  match_in,
    input  clr_total,
    input  alarm_ack,
    input  thresh,
    output total_count,
    output win_count,
    output win_valid,
    output alarm
  );
endinterface

// File: rtl/match_event_monitor.sv
// Match event monitor: edge-qualifies the detector match level, keeps a
// saturating running total, counts matches per fixed window and raises a
// sticky alarm when a closing window's count reaches the threshold.
module match_event_monitor #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned WIN_LEN = 256,
  parameter int unsigned TMR_W   = 16
) (
  input logic                clk,
  input logic                rst,
  match_event_monitor_if.slave bus
);

  localparam logic [TMR_W-1:0] TmrLast = TMR_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

  typedef enum logic [0:0] {StIdle, StAlarm} state_e;

  state_e           state_q, state_d;
  logic             match_q;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] win_count_q, win_count_d;
  logic             win_valid_q, win_valid_d;

  logic             evt;
  logic             close;
  logic [CNT_W-1:0] acc_inc;
  logic             alarm_set;

  // Event qualification, window close detect and the closing count.
  always_comb begin
    evt       = bus.en & bus.match_in & ~match_q;
    close     = bus.en & (timer_q == TmrLast);
    acc_inc   = (evt && (acc_q != CntMax)) ? acc_q + CNT_W'(1) : acc_q;
    alarm_set = close && (bus.thresh != '0) && (acc_inc >= bus.thresh);
  end

  // Datapath next state: total, window timer, accumulator and window result.
  always_comb begin
    total_d     = total_q;
    timer_d     = timer_q;
    acc_d       = acc_q;
    win_count_d = win_count_q;
    win_valid_d = 1'b0;

    // Clear beats a coincident event; the event is dropped.
    if (bus.clr_total) begin
      total_d = '0;
    end else if (evt && (total_q != CntMax)) begin
      total_d = total_q + CNT_W'(1);
    end

    if (bus.en) begin
      if (close) begin
        // An event in the close cycle belongs to the closing window.
        timer_d     = '0;
        acc_d       = '0;
        win_count_d = acc_inc;
        win_valid_d = 1'b1;
      end else begin
        timer_d = timer_q + TMR_W'(1);
        acc_d   = acc_inc;
      end
    end
  end

  // Alarm FSM next state; a set condition wins over a same-cycle ack.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (alarm_set) state_d = StAlarm;
      end
      StAlarm: begin
        if (!alarm_set && bus.alarm_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      match_q     <= 1'b0;
      timer_q     <= '0;
      acc_q       <= '0;
      total_q     <= '0;
      win_count_q <= '0;
      win_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_q     <= bus.match_in;
      timer_q     <= timer_d;
      acc_q       <= acc_d;
      total_q     <= total_d;
      win_count_q <= win_count_d;
      win_valid_q <= win_valid_d;
    end
  end

  assign bus.total_count = total_q;
  assign bus.win_count   = win_count_q;
  assign bus.win_valid   = win_valid_q;
  assign bus.alarm       = (state_q == StAlarm);

endmodule
